// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first requesting core at or after rr_ptr, wrapping.
module rr_picker
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0]        req,
  input  logic [idx_w(NUM_CORES)-1:0] rr_ptr,
  output logic                        valid,
  output logic [idx_w(NUM_CORES)-1:0] winner
);
  localparam int IW = idx_w(NUM_CORES);

  int            t;
  logic [IW-1:0] k;

  // Scan from the farthest offset down so the nearest requester is assigned last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    t      = 0;
    k      = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      t = int'(rr_ptr) + i;
      if (t >= NUM_CORES) t = t - NUM_CORES;
      k = IW'(t);
      if (req[k]) begin
        valid  = 1'b1;
        winner = k;
      end
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: round-robin over cores, optional host port
// with strict priority when DMEM_ARB_HOST_PORT_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          RESET,
  input  logic [NUM_CORES-1:0]          core_req,
  input  logic [NUM_CORES-1:0]          core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
  output logic [NUM_CORES-1:0]          core_gnt,
  output logic [NUM_CORES-1:0]          core_rvalid,
  input  logic                          host_req,
  input  logic                          host_we,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [DATA_W-1:0]             host_wdata,
  output logic                          host_gnt,
  output logic                          host_rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  output logic                          mem_re,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);
  localparam int IW = idx_w(NUM_CORES);

  state_t              state, state_nxt;
  logic [IW-1:0]       rr_ptr, win_idx, pick_idx;
  logic                pick_vld, win_host, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;

  logic                sel_host, sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_picker #(.NUM_CORES(NUM_CORES)) u_pick (
    .req    (core_req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .winner (pick_idx)
  );

  always_comb begin
    sel_host  = 1'b0;
    sel_we    = core_we[pick_idx];
    sel_addr  = core_addr[pick_idx*ADDR_W +: ADDR_W];
    sel_wdata = core_wdata[pick_idx*DATA_W +: DATA_W];
`ifdef DMEM_ARB_HOST_PORT_EN
    if (host_req) begin
      sel_host  = 1'b1;
      sel_we    = host_we;
      sel_addr  = host_addr;
      sel_wdata = host_wdata;
    end
`endif
  end

`ifndef DMEM_ARB_HOST_PORT_EN
  logic unused_host;
  assign unused_host = ^{host_req, host_we, host_addr, host_wdata};
`endif

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      win_idx  <= '0;
      win_host <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (sel_host || pick_vld)) begin
        win_host <= sel_host;
        we_q     <= sel_we;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        if (!sel_host) begin
          win_idx <= pick_idx;
          rr_ptr  <= (pick_idx == IW'(NUM_CORES - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      if (state == RDWAIT) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt   = state;
    core_gnt    = '0;
    core_rvalid = '0;
    host_gnt    = 1'b0;
    host_rvalid = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    rdata       = rdata_q;
    case (state)
      IDLE: if (sel_host || pick_vld) state_nxt = ACCESS;
      ACCESS: begin
        mem_we = we_q;
        mem_re = ~we_q;
        if (win_host) host_gnt = 1'b1;
        else          core_gnt[win_idx] = 1'b1;
        state_nxt = we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        rdata = mem_rdata;
        if (win_host) host_rvalid = 1'b1;
        else          core_rvalid[win_idx] = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_CORES, default 4, number of core requesters; ADDR_W, default 16, data-memory address width; DATA_W, default 16, data-memory word width.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  single clock; all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- core_req  in  NUM_CORES  per-core access request.
- core_we  in  NUM_CORES  per-core write enable (1 = write, 0 = read).
- core_addr  in  NUM_CORES*ADDR_W  packed addresses; core k at bits [k*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  packed write data, same packing.
- core_gnt  out  NUM_CORES  one-hot, one-cycle accept pulse.
- core_rvalid  out  NUM_CORES  one-hot, one-cycle read-data-valid pulse.
- host_req, host_we  in  1 each  host (loader/dump) request and write enable.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt, host_rvalid  out  1 each  host accept and read-valid pulses.
- rdata  out  DATA_W  read data shared by all requesters; qualified by the rvalid bits.
- mem_addr  out  ADDR_W  data-memory address.
- mem_wdata  out  DATA_W  data-memory write data.
- mem_we, mem_re  out  1 each  memory write and read strobes.
- mem_rdata  in  DATA_W  synchronous memory output, valid one cycle after mem_re.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS and RDWAIT.
REQ-004 In IDLE with any request, the block SHALL:
- pick one winner;
- register the winner's addr, we and wdata;
- go to ACCESS on the next edge.
REQ-005 In ACCESS the block SHALL:
- drive mem_addr and mem_wdata from the registers;
- assert mem_we (write) or mem_re (read) for exactly one cycle;
- pulse the winner's gnt in the same cycle.
REQ-006 After ACCESS, a write SHALL return to IDLE and a read SHALL go to RDWAIT.
REQ-007 In RDWAIT the block SHALL drive rdata = mem_rdata, pulse the winner's rvalid, then go to IDLE.
REQ-008 Latency SHALL be: write 2 cycles from req sample to return to IDLE; read 3 cycles; the rvalid cycle is 2 cycles after the sample edge.
REQ-009 Requesters SHALL hold req, we, addr and wdata stable until gnt. A req still high in the cycle after gnt SHALL be treated as a new request.
REQ-010 Core selection SHALL be round-robin starting at pointer rr_ptr.
REQ-011 On a core grant, rr_ptr SHALL become winner+1, wrapping NUM_CORES-1 to 0. rr_ptr SHALL be unchanged on host grants.
REQ-012 A request arriving while busy SHALL wait; the block SHALL NOT preempt.
REQ-013 When not in ACCESS: mem_we = mem_re = 0. When not in RDWAIT: all rvalid = 0 and rdata holds its last value.
REQ-014 core_gnt, host_gnt and the rvalid outputs SHALL never have more than one bit high in total.

Reset
REQ-015 Assertion of RESET SHALL immediately set:
- state = IDLE and rr_ptr = 0;
- all gnt, rvalid, mem_we, mem_re and busy = 0;
- mem_addr, mem_wdata and rdata = 0.
REQ-016 Reset mid-transaction SHALL drop the transaction with no gnt or rvalid afterwards. Arbitration SHALL resume on the first edge after RESET deasserts.

Configuration
REQ-017 With DMEM_ARB_HOST_PORT_EN defined, the host port SHALL take strict priority over all cores in IDLE.
REQ-018 Without DMEM_ARB_HOST_PORT_EN, host inputs SHALL be ignored and host_gnt = host_rvalid = 0 permanently.

Structure
REQ-019 Package dmem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, RDWAIT) and the default ADDR_W and DATA_W constants.
REQ-020 Round-robin selection SHALL live in sub-module rr_picker, which takes (req vector, rr_ptr) and returns (valid, winner index).

Verification
REQ-021 Single core write (NUM_CORES=4): core2 writes addr 200, data 0x0005. Required: mem_we high exactly 1 cycle with mem_addr=200 and mem_wdata=5; core_gnt=4'b0100 in that same cycle.
REQ-022 Read: core0 reads addr 10, memory preloaded 0x1234. Required: core_rvalid=4'b0001 with rdata=0x1234, 2 cycles after the sample edge.
REQ-023 Fairness: all four cores request reads continuously from reset. Required: grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-024 Host priority (macro defined): host_req and core1_req rise together. Required: host_gnt first, then core1. With the macro undefined: only core1 is granted and host_gnt stays 0.
REQ-025 Reset mid-read: RESET low in the RDWAIT cycle. Required: no rvalid, busy=0, rr_ptr=0 after release.
REQ-026 Pointer wrap: core3 granted, then cores 0 and 3 request together. Required: core0 is granted next.
